fp_sub_seq: RTL



---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_unpack_swap.sv | 30 +++
 rtl/fp_sub_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, FSM states and field helpers for the FP subtractor
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  localparam logic [4:0] ALIGN_CAP = 5'd25;
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} fp_sub_state_t;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
  } fp_fields_t;
  typedef struct packed {
    logic sign;
    logic sub;
    logic [EXP_W-1:0] exp;
    logic [MANT_W-1:0] mant_b;
    logic [MANT_W-1:0] mant_s;
    logic [4:0] cnt;
    logic sat;
  } unpack_t;
  function automatic fp_fields_t fp_split(input logic [31:0] x);
    return '{sign: x[31], exp: x[30:23], frac: x[22:0]};
  endfunction
endpackage

// File: rtl/fp_unpack_swap.sv
// fp_unpack_swap: zero detect, hidden-bit insert, magnitude order and alignment count
module fp_unpack_swap
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output unpack_t     u
);
  fp_fields_t fa, fb;
  logic [FRAC_W-1:0] ma, mb;
  logic za, zb, a_big;
  logic [EXP_W-1:0] de;
  always_comb begin
    fa = fp_split(a);
    fb = fp_split(b);
    za = fa.exp == '0;
    zb = fb.exp == '0;
    ma = za ? '0 : fa.frac;
    mb = zb ? '0 : fb.frac;
    a_big = {fa.exp, ma} >= {fb.exp, mb};
    de = a_big ? fa.exp - fb.exp : fb.exp - fa.exp;
    u.sign = a_big ? fa.sign : fb.sign;
    u.sub = fa.sign ^ fb.sign;
    u.exp = a_big ? fa.exp : fb.exp;
    u.mant_b = a_big ? {!za, ma} : {!zb, mb};
    u.mant_s = a_big ? {!zb, mb} : {!za, ma};
    u.cnt = de > {3'b0, ALIGN_CAP} ? ALIGN_CAP : de[4:0];
    u.sat = fa.exp == EXP_MAX || fb.exp == EXP_MAX;
  end
endmodule

// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle IEEE-754 single subtractor out = in1 - in2 with bit-serial align/normalize
module fp_sub_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        overFlow
);
  fp_sub_state_t state_q, state_d;
  unpack_t u;
  logic sign_q, sign_d, sub_q, sub_d, ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic [EXP_W-1:0] exp_q, exp_d, exp_inc;
  logic [MANT_W:0] big_q, big_d, sum;
  logic [MANT_W-1:0] lo_q, lo_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] out_q, out_d;
  fp_unpack_swap u_unpack (.a(in1), .b({~in2[31], in2[30:0]}), .u(u));
  assign in_ready = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign out = out_q;
  assign overFlow = ovf_q;
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    sub_d = sub_q;
    exp_d = exp_q;
    big_d = big_q;
    lo_d = lo_q;
    cnt_d = cnt_q;
    out_d = out_q;
    ovf_d = ovf_q;
    out_valid_d = out_valid_q;
    sum = sub_q ? big_q - {1'b0, lo_q} : big_q + {1'b0, lo_q};
    exp_inc = exp_q + 8'd1;
    case (state_q)
      IDLE: if (in_valid) begin
        sign_d = u.sign;
        sub_d = u.sub;
        exp_d = u.exp;
        big_d = {1'b0, u.mant_b};
        lo_d = u.mant_s;
        cnt_d = u.cnt;
        out_d = '0;
        ovf_d = u.sat;
        out_valid_d = 1'b0;
        state_d = u.sat ? DONE : ALIGN;
      end
      ALIGN: if (cnt_q == '0) state_d = ADD;
      else begin
        lo_d = lo_q >> 1;
        cnt_d = cnt_q - 5'd1;
      end
      ADD: begin
        big_d = sum[MANT_W] ? sum >> 1 : sum;
        exp_d = sum[MANT_W] ? exp_inc : exp_q;
        ovf_d = sum[MANT_W] && exp_inc == EXP_MAX;
        out_valid_d = ovf_d;
        state_d = ovf_d ? DONE : NORM;
      end
      NORM: if (big_q == '0 || big_q[MANT_W-1] || exp_q == 8'd1) begin
        out_d = big_q[MANT_W-1] ? {sign_q, exp_q, big_q[FRAC_W-1:0]} : '0;
        out_valid_d = 1'b1;
        state_d = DONE;
      end else begin
        big_d = big_q << 1;
        exp_d = exp_q - 8'd1;
      end
      DONE: begin
        out_valid_d = !(out_valid_q && out_ready);
        state_d = out_valid_q && out_ready ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      sub_q <= 1'b0;
      exp_q <= '0;
      big_q <= '0;
      lo_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      sub_q <= sub_d;
      exp_q <= exp_d;
      big_q <= big_d;
      lo_q <= lo_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
